// File: rtl/m_of_n_serial_checker.sv
// Serial M-of-N code checker: assembles N bits MSB first, flags legal
// words, and keeps saturating good/bad word statistics.
module m_of_n_serial_checker #(
  parameter int N     = 5,
  parameter int M     = 2,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             BIT_IN,
  input  logic             BIT_VALID,
  input  logic             MODE,
  input  logic             ABORT,
  input  logic             CLR_CNT,
  output logic [N-1:0]     CODE_OUT,
  output logic             DET,
  output logic             ERR,
  output logic             WORD_DONE,
  output logic             BUSY,
  output logic [CNT_W-1:0] GOOD_CNT,
  output logic [CNT_W-1:0] BAD_CNT
);

  localparam int IW = $clog2(N);
  localparam int OW = $clog2(N + 1);
  localparam logic [IW-1:0]    LAST = IW'(N - 1);
  localparam logic [OW-1:0]    M_OW = OW'(M);
  localparam logic [CNT_W-1:0] SAT  = '1;

  // the MSB of the word is only ever needed on the completing edge,
  // so the register keeps N-1 bits and the Nth comes straight from BIT_IN
  logic [N-2:0]  sh;
  logic [IW-1:0] idx;
  logic [OW-1:0] ones;

  logic [OW-1:0] ones_nxt;
  logic [N-1:0]  word_nxt;
  logic          last;
  logic          legal;
  logic          fin;

  always_comb begin
    ones_nxt = ones + OW'(BIT_IN);
    word_nxt = {sh, BIT_IN};
    last     = (idx == LAST);
    legal    = MODE ? (ones_nxt >= M_OW) : (ones_nxt == M_OW);
    fin      = BIT_VALID && !ABORT && last;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sh        <= '0;
      idx       <= '0;
      ones      <= '0;
      CODE_OUT  <= '0;
      DET       <= 1'b0;
      ERR       <= 1'b0;
      WORD_DONE <= 1'b0;
      GOOD_CNT  <= '0;
      BAD_CNT   <= '0;
    end else begin
      DET       <= fin && legal;
      ERR       <= fin && !legal;
      WORD_DONE <= fin;

      if (ABORT) begin
        sh   <= '0;
        idx  <= '0;
        ones <= '0;
      end else if (BIT_VALID) begin
        if (last) begin
          CODE_OUT <= word_nxt;
          sh       <= '0;
          idx      <= '0;
          ones     <= '0;
        end else begin
          sh   <= word_nxt[N-2:0];
          idx  <= idx + IW'(1);
          ones <= ones_nxt;
        end
      end

      // clear beats a coincident completion
      if (CLR_CNT) begin
        GOOD_CNT <= '0;
        BAD_CNT  <= '0;
      end else if (fin) begin
        if (legal && GOOD_CNT != SAT)
          GOOD_CNT <= GOOD_CNT + CNT_W'(1);
        if (!legal && BAD_CNT != SAT)
          BAD_CNT <= BAD_CNT + CNT_W'(1);
      end
    end
  end

  assign BUSY = (idx != '0);

endmodule

// File: doc/m_of_n_serial_checker.md
Name: m_of_n_serial_checker

Overview:
Serial M-of-N code checker, the sequential and parametrised successor to the 5-bit two-of-five detector (task1). Code bits arrive one per accepted cycle, MSB first, on a valid-qualified serial input. After N bits the block reports whether the word is a legal M-of-N code word, exposes the assembled word, and keeps saturating good/bad word statistics. It sits between the serial receive front end and the code-word consumer.

Parameters:
N, 5, code word length in bits (N >= 2)
M, 2, required count of 1 bits (0 <= M <= N)
CNT_W, 8, width of the statistics counters

Ports:
CLK  input  1  rising-edge clock
RST_N  input  1  synchronous active-low reset, sampled on CLK rising edge
BIT_IN  input  1  serial code bit, MSB first
BIT_VALID  input  1  BIT_IN is accepted on this cycle
MODE  input  1  0 = exactly M ones is legal, 1 = at least M ones is legal; sampled when the Nth bit is accepted
ABORT  input  1  discard the partial word in progress
CLR_CNT  input  1  clear GOOD_CNT and BAD_CNT
CODE_OUT  output  N  last completed word, first-received bit in MSB
DET  output  1  one-cycle pulse: completed word is legal
ERR  output  1  one-cycle pulse: completed word is illegal
WORD_DONE  output  1  one-cycle pulse: a word completed (DET or ERR)
BUSY  output  1  at least one bit of a word has been accepted and the word is not yet complete
GOOD_CNT  output  CNT_W  saturating count of legal words
BAD_CNT  output  CNT_W  saturating count of illegal words

Behaviour:
- Reset (RST_N=0 at a clock edge): all outputs 0, bit counter 0, ones counter 0, shift register 0. Reset overrides every other input, including a word in mid-reception, and discards the partial word.
- Internal state: shift register (N bits), bit index 0..N-1, ones counter of width clog2(N+1).
- Accept: on an edge with BIT_VALID=1, BIT_IN shifts in at the LSB, the ones counter adds BIT_IN, and the bit index increments. BUSY=1 from the cycle after the first bit until the Nth bit has been accepted.
- Completion: on the edge that accepts the Nth bit, these take effect together and are visible the following cycle (1-cycle latency):
  - CODE_OUT loads the full word.
  - legal = (ones==M) when MODE=0, or (ones>=M) when MODE=1. The ones value includes the Nth bit.
  - DET=legal, ERR=!legal, WORD_DONE=1, each for exactly one cycle.
  - On the same edge the bit index and ones counter return to 0, and BUSY=0.
- CODE_OUT holds its value until the next completion.
- Back-to-back operation: a bit accepted in the cycle where DET/ERR is high is the first bit of the next word. No bubble is required, so a sustained N-bit stream produces one pulse every N cycles.
- BIT_VALID=0 stalls: all state holds and gaps of any length are allowed within a word.
- ABORT=1: bit index, ones counter and shift register clear and BUSY=0. No pulse is issued and the statistics are unchanged. If ABORT and BIT_VALID are both high, ABORT wins, the bit is dropped, and even an Nth bit produces no completion.
- Statistics:
  - GOOD_CNT increments on each legal completion and BAD_CNT on each illegal one.
  - Each counter saturates at 2^CNT_W-1 and does not wrap.
  - CLR_CNT=1 sets both counters to 0. If CLR_CNT coincides with a completion edge, the clear wins: the counters read 0, but DET/ERR/CODE_OUT still update normally.
- Edge cases:
  - M=0 with MODE=1: every word is legal.
  - M=N with MODE=0: only the all-ones word is legal.

Test Plan:
- N=5, M=2, MODE=0. Stream 11000, 01100, 00011, 00101, 10100, 01010 back-to-back, then 11111, 00000, 11110, 00001 -> first six words give DET pulses, last four give ERR pulses, one pulse every 5 cycles; CODE_OUT equals each word; GOOD_CNT=6, BAD_CNT=4.
- MODE=1, stream 11110 -> DET=1 (4>=2); same word with MODE=0 -> ERR=1; word 00001 with MODE=1 -> ERR=1.
- Send bits 1,1,0 then ABORT, then full word 00011 with BIT_VALID gaps of 0-3 cycles -> no pulse after the abort; a single DET after the 5th accepted bit; GOOD_CNT +1 only.
- Assert RST_N=0 after 3 bits of 10100, release, send 00101 -> all outputs 0 during reset; one DET with CODE_OUT=00101 and no stale ones count.
- CNT_W=2: send 5 legal words -> GOOD_CNT sequence 1,2,3,3,3. Assert CLR_CNT on the completion cycle of an illegal word -> ERR pulses, BAD_CNT=0.
- ABORT and BIT_VALID high together on the 5th bit -> no WORD_DONE, BUSY=0, counters unchanged.
